// File: rtl/pico_l15_arbiter.sv
// pico_l15_arbiter: round-robin merge of two pico-style requesters onto one L1.5 port.
// Define PICO_ARB_WDT_EN to add the response watchdog (TIMEOUT_CYCLES).
`ifndef L15_AMO_OP_WIDTH
`define L15_AMO_OP_WIDTH 4
`endif

module pico_l15_arbiter #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req0_valid,
    input  logic [31:0]                  req0_addr,
    input  logic [3:0]                   req0_wstrb,
    input  logic [31:0]                  req0_wdata,
    input  logic [`L15_AMO_OP_WIDTH-1:0] req0_amo_op,
    output logic                         req0_ready,
    output logic [31:0]                  req0_rdata,
    input  logic                         req1_valid,
    input  logic [31:0]                  req1_addr,
    input  logic [3:0]                   req1_wstrb,
    input  logic [31:0]                  req1_wdata,
    input  logic [`L15_AMO_OP_WIDTH-1:0] req1_amo_op,
    output logic                         req1_ready,
    output logic [31:0]                  req1_rdata,
    output logic                         arb_mem_valid,
    output logic [31:0]                  arb_mem_addr,
    output logic [3:0]                   arb_mem_wstrb,
    output logic [31:0]                  arb_mem_wdata,
    output logic [`L15_AMO_OP_WIDTH-1:0] arb_mem_amo_op,
    input  logic                         l15_arb_ack,
    input  logic                         l15_arb_resp_val,
    input  logic [31:0]                  l15_arb_resp_data,
    output logic                         arb_timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP,
        GAP
    } state_t;

    state_t state_q, state_d;
    logic last_grant_q, last_grant_d;
    logic grant;
    logic valid_q, valid_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0] wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [`L15_AMO_OP_WIDTH-1:0] amo_q, amo_d;
    logic ready0_q, ready0_d;
    logic ready1_q, ready1_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic done;
    logic [31:0] done_data;

`ifdef PICO_ARB_WDT_EN
    localparam logic [9:0] TMO = 10'(TIMEOUT_CYCLES);
    logic [9:0] wdt_q, wdt_d;
    logic err_q, err_d;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant        = last_grant_q;
        valid_d      = valid_q;
        addr_d       = addr_q;
        wstrb_d      = wstrb_q;
        wdata_d      = wdata_q;
        amo_d        = amo_q;
        ready0_d     = 1'b0;
        ready1_d     = 1'b0;
        rdata0_d     = 32'h0;
        rdata1_d     = 32'h0;
        done         = 1'b0;
        done_data    = l15_arb_resp_data;
`ifdef PICO_ARB_WDT_EN
        wdt_d        = wdt_q;
        err_d        = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant = (req0_valid && req1_valid) ? ~last_grant_q
                                                       : req1_valid;
                    last_grant_d = grant;
                    addr_d  = grant ? req1_addr   : req0_addr;
                    wstrb_d = grant ? req1_wstrb  : req0_wstrb;
                    wdata_d = grant ? req1_wdata  : req0_wdata;
                    amo_d   = grant ? req1_amo_op : req0_amo_op;
                    valid_d = 1'b1;
                    state_d = ISSUE;
`ifdef PICO_ARB_WDT_EN
                    wdt_d   = 10'd0;
`endif
                end
            end
            ISSUE, WAIT_RESP: begin
                // A response implies the ack, so it wins over the ISSUE->WAIT_RESP step
                if (l15_arb_resp_val) begin
                    done = 1'b1;
                end else if (state_q == ISSUE && l15_arb_ack) begin
                    state_d = WAIT_RESP;
                end
`ifdef PICO_ARB_WDT_EN
                if (!l15_arb_resp_val) begin
                    if (wdt_q == TMO) begin
                        done      = 1'b1;
                        done_data = 32'hDEAD_BEEF;
                        err_d     = 1'b1;
                    end else if (wdt_q != 10'h3ff) begin
                        wdt_d = wdt_q + 10'd1;
                    end
                end
`endif
                if (done) begin
                    valid_d = 1'b0;
                    state_d = GAP;
                    if (last_grant_q) begin
                        ready1_d = 1'b1;
                        rdata1_d = done_data;
                    end else begin
                        ready0_d = 1'b1;
                        rdata0_d = done_data;
                    end
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            valid_q      <= 1'b0;
            addr_q       <= 32'h0;
            wstrb_q      <= 4'h0;
            wdata_q      <= 32'h0;
            amo_q        <= '0;
            ready0_q     <= 1'b0;
            ready1_q     <= 1'b0;
            rdata0_q     <= 32'h0;
            rdata1_q     <= 32'h0;
`ifdef PICO_ARB_WDT_EN
            wdt_q        <= 10'd0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            valid_q      <= valid_d;
            addr_q       <= addr_d;
            wstrb_q      <= wstrb_d;
            wdata_q      <= wdata_d;
            amo_q        <= amo_d;
            ready0_q     <= ready0_d;
            ready1_q     <= ready1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
`ifdef PICO_ARB_WDT_EN
            wdt_q        <= wdt_d;
            err_q        <= err_d;
`endif
        end
    end

    assign arb_mem_valid  = valid_q;
    assign arb_mem_addr   = addr_q;
    assign arb_mem_wstrb  = wstrb_q;
    assign arb_mem_wdata  = wdata_q;
    assign arb_mem_amo_op = amo_q;
    assign req0_ready     = ready0_q;
    assign req1_ready     = ready1_q;
    assign req0_rdata     = rdata0_q;
    assign req1_rdata     = rdata1_q;
`ifdef PICO_ARB_WDT_EN
    assign arb_timeout_err = err_q;
`else
    assign arb_timeout_err = 1'b0;
`endif

endmodule

// File: doc/pico_l15_arbiter.md
PICO_L15_ARBITER -- requirements
Module: pico_l15_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1023, meaning the response-wait cycles before watchdog abort (used only with PICO_ARB_WDT_EN).
REQ-002 The block SHALL have the port clk, input, 1 bit: clock.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have reqN_valid, input, 1 bit, N=0,1: requester N holds this high until its ready pulse.
REQ-005 The block SHALL have reqN_addr, input, 32 bits, N=0,1: byte address.
REQ-006 The block SHALL have reqN_wstrb, input, 4 bits, N=0,1: write strobes; 0 means load.
REQ-007 The block SHALL have reqN_wdata, input, 32 bits, N=0,1: store data.
REQ-008 The block SHALL have reqN_amo_op, input, `L15_AMO_OP_WIDTH bits, N=0,1: atomic opcode.
REQ-009 The block SHALL have reqN_ready, output, 1 bit, N=0,1: one-cycle completion pulse.
REQ-010 The block SHALL have reqN_rdata, output, 32 bits, N=0,1: load data, valid with reqN_ready.
REQ-011 The block SHALL have arb_mem_valid, arb_mem_addr[31:0], arb_mem_wstrb[3:0], arb_mem_wdata[31:0] and arb_mem_amo_op, all outputs: the single downstream pico-style request toward the L1.5 decoder.
REQ-012 The block SHALL have l15_arb_ack, input, 1 bit: the request was accepted by the L1.5.
REQ-013 The block SHALL have l15_arb_resp_val, input, 1 bit: response present.
REQ-014 The block SHALL have l15_arb_resp_data, input, 32 bits: response data.
REQ-015 The block SHALL have arb_timeout_err, output, 1 bit: sticky watchdog flag.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT_RESP and GAP; all outputs SHALL be registered.
REQ-017 In IDLE with any reqN_valid high, the block SHALL latch the winner's addr, wstrb, wdata and amo_op, record grant, and move to ISSUE; arb_mem_valid SHALL rise the next cycle.
REQ-018 Arbitration SHALL be round-robin: a sole requester wins; when both request, the one not granted last wins; last_grant SHALL reset to 1, so req0 wins the first tie.
REQ-019 In ISSUE, arb_mem_valid SHALL be 1; l15_arb_ack SHALL move the FSM to WAIT_RESP with valid held high.
REQ-020 l15_arb_resp_val in ISSUE or WAIT_RESP SHALL complete the transaction (an ack in the same cycle is implied): the granted reqG_ready SHALL pulse for exactly 1 cycle with reqG_rdata = l15_arb_resp_data, and the FSM SHALL go to GAP.
REQ-021 arb_mem_valid SHALL be 0 in GAP and IDLE, guaranteeing at least 1 low cycle between consecutive requests so the decoder sees a fresh rising edge.
REQ-022 GAP SHALL last 1 cycle and then return to IDLE; requester valids SHALL be ignored in GAP.
REQ-023 A non-granted reqN_ready SHALL stay 0, and its reqN_rdata SHALL be 0.
REQ-024 Latched payload SHALL be immune to requester input changes; if the granted requester drops valid mid-transaction, the transaction SHALL still complete and pulse ready.
REQ-025 A response or ack arriving in IDLE or GAP SHALL be ignored.

Reset
REQ-026 On rst_n=0 at a clk edge: state=IDLE, last_grant=1, arb_mem_valid=0, arb_mem_* payload=0, reqN_ready=0, reqN_rdata=0, arb_timeout_err=0, watchdog count=0.
REQ-027 Reset mid-transaction SHALL abandon the transaction with no ready pulse.

Configuration
REQ-028 With macro PICO_ARB_WDT_EN defined, a 10-bit saturating counter SHALL clear on entering ISSUE and increment each cycle in ISSUE or WAIT_RESP.
REQ-029 With PICO_ARB_WDT_EN defined, when the counter equals TIMEOUT_CYCLES and no response arrives, the block SHALL pulse reqG_ready with rdata=32'hDEADBEEF, set arb_timeout_err (sticky until reset), and go to GAP.
REQ-030 Without PICO_ARB_WDT_EN, no counter SHALL exist, arb_timeout_err SHALL be tied 0, and the block SHALL wait indefinitely.

Verification
REQ-031 req0 load addr 32'h8000_0010; ack at cycle+2, resp 32'h1234_5678 at cycle+5 -> req0_ready 1 cycle, req0_rdata=32'h1234_5678, valid low >=1 cycle after.
REQ-032 req0 and req1 asserted together out of reset -> req0 served first, req1 next; repeated ties alternate 0,1,0,1.
REQ-033 req1 store wstrb=4'b0011 wdata 32'hAABB_CCDD, ack and resp in the same cycle -> single completion, arb_mem_wstrb=4'b0011, FSM to GAP.
REQ-034 rst_n low while in WAIT_RESP -> all outputs 0 next cycle, no ready pulse, late resp ignored.
REQ-035 With PICO_ARB_WDT_EN and TIMEOUT_CYCLES=16, no response -> reqG_ready pulses with rdata 32'hDEADBEEF and arb_timeout_err=1 and stays set; without the macro -> no pulse, err=0.
